// File: rtl/mul_job_sched_pkg.sv
// Shared types for the FrodoKEM multiplier job scheduler: datapath modes,
// scheduler FSM states and completion codes.
package mul_job_sched_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned CODE_W = 2;

    // Also decoded by the memory controller; keep encodings stable.
    typedef enum logic [MODE_W-1:0] {
        MODE_IDLE = 3'd0,
        MODE_AS   = 3'd1,
        MODE_SA   = 3'd2,
        MODE_SB   = 3'd3,
        MODE_BS   = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_RESP
    } state_e;

    typedef enum logic [CODE_W-1:0] {
        RSP_OK       = 2'd0,
        RSP_BAD_MODE = 2'd1,
        RSP_TIMEOUT  = 2'd2,
        RSP_ABORTED  = 2'd3
    } rsp_code_e;

    function automatic logic mode_is_job(input logic [MODE_W-1:0] m);
        return (m >= MODE_AS) && (m <= MODE_BS);
    endfunction

endpackage

// File: rtl/mul_job_sched_fifo.sv
// Command FIFO with registered status and head outputs plus a synchronous flush.
// head_vld/dout trail the occupancy by one cycle, so pops must be spaced apart.
module mul_job_sched_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             head_vld
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_push   = push && !full && !flush;
        do_pop    = pop && (count != '0) && !flush;
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            head_vld <= 1'b0;
            dout     <= '0;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
            dout  <= mem[rd_ptr];
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                head_vld <= 1'b0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)
                    rd_ptr <= rd_ptr + 1'b1;
                head_vld <= (count != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mul_job_sched.sv
// Job scheduler in front of the multiplier top: queues AS/SA/SB/BS commands and
// runs them one at a time. Define MUL_JOB_SCHED_TIMEOUT_EN to build the RUN watchdog.
module mul_job_sched
    import mul_job_sched_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TAG_W          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_mode,
    input  logic [TAG_W-1:0]  cmd_tag,
    input  logic              abort,
    output logic [2:0]        mem_mode,
    output logic              calc_init,
    input  logic              mul_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [1:0]        rsp_code,
    output logic              busy
);

    state_e                    state;
    state_e                    state_nxt;
    logic [MODE_W-1:0]         mode_q;
    logic [MODE_W-1:0]         mode_nxt;
    logic [MODE_W-1:0]         mem_mode_nxt;
    logic [TAG_W-1:0]          tag_nxt;
    logic [CODE_W-1:0]         code_nxt;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      head_vld;
    logic [MODE_W+TAG_W-1:0]   head;
    logic                      wd_expired;

    mul_job_sched_fifo #(
        .WIDTH (MODE_W + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .push     (cmd_valid),
        .din      ({cmd_mode, cmd_tag}),
        .full     (fifo_full),
        .pop      (fifo_pop),
        .dout     (head),
        .empty    (fifo_empty),
        .head_vld (head_vld)
    );

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);

`ifdef MUL_JOB_SCHED_TIMEOUT_EN
    localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == ST_LAUNCH)
            wd_cnt <= '0;
        else if (state == ST_RUN)
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expired = (state == ST_RUN) && (wd_cnt == WD_LAST);
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign wd_expired     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        mode_nxt  = mode_q;
        tag_nxt   = rsp_tag;
        code_nxt  = rsp_code;
        case (state)
            ST_IDLE: begin
                if (head_vld && !abort) begin
                    fifo_pop = 1'b1;
                    mode_nxt = head[MODE_W+TAG_W-1:TAG_W];
                    tag_nxt  = head[TAG_W-1:0];
                    if (mode_is_job(mode_nxt)) begin
                        state_nxt = ST_LAUNCH;
                    end else begin
                        state_nxt = ST_RESP;
                        code_nxt  = RSP_BAD_MODE;
                    end
                end
            end
            ST_LAUNCH, ST_RUN: begin
                // mul_done takes priority over a watchdog expiry in the same cycle
                if (abort) begin
                    state_nxt = ST_RESP;
                    code_nxt  = RSP_ABORTED;
                end else if (state == ST_LAUNCH) begin
                    state_nxt = ST_RUN;
                end else if (mul_done) begin
                    state_nxt = ST_RESP;
                    code_nxt  = RSP_OK;
                end else if (wd_expired) begin
                    state_nxt = ST_RESP;
                    code_nxt  = RSP_TIMEOUT;
                end
            end
            ST_RESP: begin
                if (rsp_ready)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        mem_mode_nxt = ((state_nxt == ST_LAUNCH) || (state_nxt == ST_RUN)) ? mode_nxt : MODE_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_IDLE;
            mem_mode  <= MODE_IDLE;
            calc_init <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_tag   <= '0;
            rsp_code  <= RSP_OK;
        end else begin
            state     <= state_nxt;
            mode_q    <= mode_nxt;
            mem_mode  <= mem_mode_nxt;
            calc_init <= (state_nxt == ST_LAUNCH);
            rsp_valid <= (state_nxt == ST_RESP);
            rsp_tag   <= tag_nxt;
            rsp_code  <= code_nxt;
        end
    end

endmodule

// File: tb/tb_mul_job_sched.sv
// Scoreboard bench for mul_job_sched: directed jobs push expected responses,
// a negedge monitor pops and compares them and checks launch spacing.
module tb_mul_job_sched;

    localparam int unsigned TAG_W = 4;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [1:0]       code;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_mode = 3'd0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic             abort = 1'b0;
    logic [2:0]       mem_mode;
    logic             calc_init;
    logic             mul_done = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [TAG_W-1:0] rsp_tag;
    logic [1:0]       rsp_code;
    logic             busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    int   launches = 0;
    int   idle_run = 0;
    bit   prev_ci = 1'b0;
    int   job_len = 20;
    bit   auto_en = 1'b1;

    always #5 clk = ~clk;

    mul_job_sched #(
        .FIFO_DEPTH     (4),
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_tag   (cmd_tag),
        .abort     (abort),
        .mem_mode  (mem_mode),
        .calc_init (calc_init),
        .mul_done  (mul_done),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_tag   (rsp_tag),
        .rsp_code  (rsp_code),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] m, input logic [TAG_W-1:0] t, input logic [1:0] code,
                        input bit expect_rsp, output bit acc);
        exp_t e;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_tag   = t;
        @(negedge clk);
        acc = cmd_ready;
        tick();
        cmd_valid = 1'b0;
        if (acc && expect_rsp) begin
            e.tag  = t;
            e.code = code;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_calc(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (calc_init) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: calc_init not seen within 200 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name, input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (sb_q.size() == 0 && !busy && !rsp_valid)
                break;
            tick();
        end
        checks++;
        if (i == bound) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles, pending %0d busy %0d", name, bound, sb_q.size(), busy);
        end
    endtask

    // Multiplier model: pulses mul_done job_len cycles after calc_init unless aborted.
    initial begin
        bit killed;
        forever begin
            @(posedge clk);
            #2;
            if (calc_init && auto_en) begin
                killed = 1'b0;
                for (int i = 0; i < job_len; i++) begin
                    @(posedge clk);
                    #2;
                    if (abort || !rst_n) begin
                        killed = 1'b1;
                        break;
                    end
                end
                if (!killed) begin
                    mul_done = 1'b1;
                    @(posedge clk);
                    #2;
                    mul_done = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got tag %0d code %0d, expected no response", rsp_tag, rsp_code);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_tag", int'(rsp_tag), int'(e.tag));
                    chk("rsp_code", int'(rsp_code), int'(e.code));
                end
            end
            if (calc_init) begin
                chk("launch_mode_nonzero", int'(mem_mode != 3'd0), 1);
                chk("calc_init_width", int'(prev_ci), 0);
                if (launches > 0)
                    chk("idle_gap_ge2", int'(idle_run >= 2), 1);
                launches++;
            end
            idle_run = (mem_mode == 3'd0) ? idle_run + 1 : 0;
            prev_ci  = calc_init;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit   acc;
        bit   stable;
        int   n;
        int   l0;

        #12;
        chk("reset_mem_mode", int'(mem_mode), 0);
        chk("reset_calc_init", int'(calc_init), 0);
        chk("reset_rsp_valid", int'(rsp_valid), 0);
        chk("reset_rsp_tag", int'(rsp_tag), 0);
        chk("reset_rsp_code", int'(rsp_code), 0);
        chk("reset_cmd_ready", int'(cmd_ready), 1);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single AS job, 100-cycle multiplication
        job_len = 100;
        auto_en = 1'b1;
        push(3'd1, 4'd5, 2'd0, 1'b1, acc);
        chk("t1_accept", int'(acc), 1);
        tick();
        chk("t1_calc_init_t1", int'(calc_init), 0);
        tick();
        chk("t1_calc_init_t2", int'(calc_init), 1);
        chk("t1_mode_launch", int'(mem_mode), 1);
        n = 0;
        repeat (100) begin
            tick();
            if (mem_mode == 3'd1 && !calc_init)
                n++;
        end
        chk("t1_mode_held", n, 100);
        tick();
        chk("t1_rsp_valid", int'(rsp_valid), 1);
        chk("t1_mode_idle", int'(mem_mode), 0);
        wait_drain("t1_drain", 50);

        // Illegal modes answer BAD_MODE without touching the datapath
        l0 = launches;
        push(3'd6, 4'd7, 2'd1, 1'b1, acc);
        tick();
        chk("bad_rsp_t1", int'(rsp_valid), 0);
        tick();
        chk("bad_rsp_t2", int'(rsp_valid), 1);
        wait_drain("bad6_drain", 50);
        push(3'd0, 4'd8, 2'd1, 1'b1, acc);
        wait_drain("bad0_drain", 50);
        chk("bad_no_launch", launches, l0);

        // Stalled response while filling the FIFO behind it
        job_len   = 20;
        rsp_ready = 1'b0;
        push(3'd3, 4'd9, 2'd0, 1'b1, acc);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("stall_rsp_seen", int'(rsp_valid), 1);
        l0 = launches;
        stable = 1'b1;
        push(3'd2, 4'd1, 2'd0, 1'b1, acc);
        chk("fill_push1", int'(acc), 1);
        if (!rsp_valid || rsp_tag != 4'd9 || rsp_code != 2'd0) stable = 1'b0;
        push(3'd3, 4'd2, 2'd0, 1'b1, acc);
        chk("fill_push2", int'(acc), 1);
        if (!rsp_valid || rsp_tag != 4'd9 || rsp_code != 2'd0) stable = 1'b0;
        push(3'd4, 4'd3, 2'd0, 1'b1, acc);
        chk("fill_push3", int'(acc), 1);
        if (!rsp_valid || rsp_tag != 4'd9 || rsp_code != 2'd0) stable = 1'b0;
        push(3'd1, 4'd4, 2'd0, 1'b1, acc);
        chk("fill_push4", int'(acc), 1);
        if (!rsp_valid || rsp_tag != 4'd9 || rsp_code != 2'd0) stable = 1'b0;
        push(3'd2, 4'd6, 2'd0, 1'b1, acc);
        chk("fifo_full_blocks", int'(acc), 0);
        repeat (5) begin
            tick();
            if (!rsp_valid || rsp_tag != 4'd9 || rsp_code != 2'd0) stable = 1'b0;
        end
        chk("stall_rsp_stable", int'(stable), 1);
        chk("stall_no_launch", launches, l0);
        rsp_ready = 1'b1;
        wait_drain("fill_drain", 1000);

`ifdef MUL_JOB_SCHED_TIMEOUT_EN
        auto_en = 1'b0;
        push(3'd2, 4'd3, 2'd2, 1'b1, acc);
        wait_calc("to_launch");
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, 17);
        wait_drain("timeout_drain", 50);
        auto_en = 1'b1;
        job_len = 16;
        push(3'd2, 4'd4, 2'd0, 1'b1, acc);
        wait_drain("done_at_limit_drain", 100);
`else
        job_len = 40;
        push(3'd2, 4'd3, 2'd0, 1'b1, acc);
        wait_calc("long_launch");
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk("long_job_latency", n, 41);
        wait_drain("long_drain", 50);
`endif

        // Abort during RUN with two jobs queued; push in the abort cycle is dropped
        job_len = 1000;
        push(3'd1, 4'd10, 2'd3, 1'b1, acc);
        push(3'd2, 4'd11, 2'd0, 1'b0, acc);
        push(3'd3, 4'd12, 2'd0, 1'b0, acc);
        wait_calc("abort_launch");
        repeat (5) tick();
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 3'd4;
        cmd_tag   = 4'd13;
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        chk("abort_rsp_valid", int'(rsp_valid), 1);
        chk("abort_mode_idle", int'(mem_mode), 0);
        tick();
        tick();
        chk("abort_busy", int'(busy), 0);
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        l0 = launches;
        n = 0;
        repeat (10) begin
            tick();
            if (rsp_valid)
                n++;
        end
        chk("abort_no_more_rsp", n, 0);
        chk("abort_no_launch", launches, l0);

        // Asynchronous reset in the middle of a job
        auto_en = 1'b0;
        push(3'd1, 4'd14, 2'd0, 1'b0, acc);
        wait_calc("reset_job_launch");
        repeat (3) tick();
        chk("prereset_mode", int'(mem_mode), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_mode", int'(mem_mode), 0);
        chk("async_reset_busy", int'(busy), 0);
        chk("async_reset_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle", int'(busy), 0);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
